// File: rtl/bw_io_ddr_pkg.sv
// Shared definitions for the DDR byte-lane write path.
// Holds the sequencer state encoding, burst-length constants and the
// preamble/postamble framing lengths, plus a helper giving the last beat index.
package bw_io_ddr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_BURST = 2'd2,
        ST_POST  = 2'd3
    } tx_state_t;

    localparam int unsigned BURST_LEN4    = 4;
    localparam int unsigned BURST_LEN8    = 8;
    localparam int unsigned PREAMBLE_LEN  = 1;
    localparam int unsigned POSTAMBLE_LEN = 1;

    // Beat/phase counter width: covers the longest burst and framing phases.
    localparam int unsigned BCNT_W = 3;

    // Index of the final beat for the latched burst length.
    function automatic logic [BCNT_W-1:0] last_beat(input logic len8);
        return len8 ? BCNT_W'(BURST_LEN8 - 1) : BCNT_W'(BURST_LEN4 - 1);
    endfunction

endpackage

// File: rtl/bw_io_ddr_txfifo.sv
// Synchronous beat FIFO for the DDR write lane (no fall-through).
// Ports:
//   clk, rst_l       clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data  write one beat when push & !full
//   pop              drop the head beat when pop & !empty
//   head             current head beat (valid when !empty)
//   full, empty      occupancy flags, decoded from the registered count
//   count            registered occupancy, log2(DEPTH)+1 bits
module bw_io_ddr_txfifo #(
    parameter int unsigned LANES = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       push,
    input  logic [LANES-1:0]           push_data,
    input  logic                       pop,
    output logic [LANES-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [LANES-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/bw_io_ddr_dq_tx_ctl.sv
// Write-burst sequencer for one DDR byte lane.
// Buffers write beats in a FIFO and replays each commanded burst onto the pad
// drivers framed by a preamble and postamble; gates ODT off while driving.
// Ports:
//   clk, rst_l                 clock, asynchronous active-low reset
//   wr_vld, wr_data, wr_rdy    beat write handshake (wr_rdy = FIFO not full)
//   burst_go, burst_len8       burst command (1 = 8 beats, 0 = 4 beats)
//   cmd_rdy                    command accepted this cycle
//   odt_req                    controller termination request
//   clr_err                    clears the sticky underflow flag
//   pad_data, pad_oe           registered pad drive data / output enable
//   odt_enable                 registered, gated termination enable
//   busy                       sequencer not idle
//   underflow                  sticky: a beat slot found the FIFO empty
module bw_io_ddr_dq_tx_ctl
    import bw_io_ddr_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             wr_vld,
    input  logic [LANES-1:0] wr_data,
    output logic             wr_rdy,
    input  logic             burst_go,
    input  logic             burst_len8,
    output logic             cmd_rdy,
    input  logic             odt_req,
    input  logic             clr_err,
    output logic [LANES-1:0] pad_data,
    output logic             pad_oe,
    output logic             odt_enable,
    output logic             busy,
    output logic             underflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic              len8;
    logic              len8_nxt;
    logic [BCNT_W-1:0] bcnt;
    logic [BCNT_W-1:0] bcnt_nxt;
    logic              last_c;
    logic              beat_slot_c;
    logic              pop_c;
    logic              ufl_set_c;
    logic [LANES-1:0]  pad_data_nxt;

    logic [LANES-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;
    logic              unused_fifo_cnt;

    bw_io_ddr_txfifo #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_txfifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (wr_vld),
        .push_data (wr_data),
        .pop       (pop_c),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    // Occupancy is only needed through the full/empty flags here.
    assign unused_fifo_cnt = ^fifo_cnt;

    // Handshakes decode registered state only.
    assign last_c  = (state == ST_BURST) && (bcnt == last_beat(len8));
    assign cmd_rdy = (state == ST_IDLE) || last_c;
    assign wr_rdy  = !fifo_full;

    // Next state; bcnt doubles as the phase counter for PRE/POST framing.
    always_comb begin
        state_nxt = state;
        len8_nxt  = len8;
        bcnt_nxt  = bcnt;
        unique case (state)
            ST_IDLE: begin
                if (burst_go) begin
                    state_nxt = ST_PRE;
                    len8_nxt  = burst_len8;
                    bcnt_nxt  = '0;
                end
            end
            ST_PRE: begin
                if (bcnt == BCNT_W'(PREAMBLE_LEN - 1)) begin
                    state_nxt = ST_BURST;
                    bcnt_nxt  = '0;
                end else begin
                    bcnt_nxt = bcnt + BCNT_W'(1);
                end
            end
            ST_BURST: begin
                if (last_c) begin
                    bcnt_nxt = '0;
                    if (burst_go) begin
                        len8_nxt = burst_len8;
                    end else begin
                        state_nxt = ST_POST;
                    end
                end else begin
                    bcnt_nxt = bcnt + BCNT_W'(1);
                end
            end
            ST_POST: begin
                if (bcnt == BCNT_W'(POSTAMBLE_LEN - 1)) begin
                    state_nxt = ST_IDLE;
                    bcnt_nxt  = '0;
                end else begin
                    bcnt_nxt = bcnt + BCNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                bcnt_nxt  = '0;
            end
        endcase

        // The head is popped as it is loaded into the pad_data register.
        beat_slot_c  = (state_nxt == ST_BURST);
        pop_c        = beat_slot_c && !fifo_empty;
        ufl_set_c    = beat_slot_c && fifo_empty;
        pad_data_nxt = pop_c ? fifo_head : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= ST_IDLE;
            len8       <= 1'b0;
            bcnt       <= '0;
            pad_data   <= '0;
            pad_oe     <= 1'b0;
            odt_enable <= 1'b0;
            busy       <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            state      <= state_nxt;
            len8       <= len8_nxt;
            bcnt       <= bcnt_nxt;
            pad_data   <= pad_data_nxt;
            pad_oe     <= (state_nxt != ST_IDLE);
            busy       <= (state_nxt != ST_IDLE);
            odt_enable <= odt_req && (state_nxt == ST_IDLE) && !burst_go;
            if (ufl_set_c) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bw_io_ddr_dq_tx_ctl.sv
// Self-checking bench for bw_io_ddr_dq_tx_ctl: directed scenarios plus
// randomized bursts checked against a queue-based reference of the lane.
module tb_bw_io_ddr_dq_tx_ctl;

    localparam int LANES = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst_l;
    logic             wr_vld;
    logic [LANES-1:0] wr_data;
    logic             wr_rdy;
    logic             burst_go;
    logic             burst_len8;
    logic             cmd_rdy;
    logic             odt_req;
    logic             clr_err;
    logic [LANES-1:0] pad_data;
    logic             pad_oe;
    logic             odt_enable;
    logic             busy;
    logic             underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: beats waiting in the lane, and the sticky error flag.
    logic [LANES-1:0] model_q[$];
    logic             model_ufl;

    bw_io_ddr_dq_tx_ctl #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .wr_vld     (wr_vld),
        .wr_data    (wr_data),
        .wr_rdy     (wr_rdy),
        .burst_go   (burst_go),
        .burst_len8 (burst_len8),
        .cmd_rdy    (cmd_rdy),
        .odt_req    (odt_req),
        .clr_err    (clr_err),
        .pad_data   (pad_data),
        .pad_oe     (pad_oe),
        .odt_enable (odt_enable),
        .busy       (busy),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [LANES-1:0] d);
        wr_vld  = 1'b1;
        wr_data = d;
        if (wr_rdy) model_q.push_back(d);
        tick();
        wr_vld = 1'b0;
    endtask

    task automatic start_burst(input logic l8);
        burst_go   = 1'b1;
        burst_len8 = l8;
        tick();
        burst_go = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        odt_req = 1'b1;
        repeat (2) tick();
        n_tests++; if (pad_oe !== 1'b0) begin n_fail++; $display("FAIL rst_pad_oe got %0b exp 0", pad_oe); end
        n_tests++; if (odt_enable !== 1'b0) begin n_fail++; $display("FAIL rst_odt got %0b exp 0", odt_enable); end
        n_tests++; if (pad_data !== 8'h00) begin n_fail++; $display("FAIL rst_pad_data got %0h exp 0", pad_data); end
        n_tests++; if (busy !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL rst_busy_ufl got %0b%0b exp 00", busy, underflow); end
        n_tests++; if (cmd_rdy !== 1'b1 || wr_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy got %0b%0b exp 11", cmd_rdy, wr_rdy); end
        rst_l = 1'b1;
        tick();
        n_tests++; if (odt_enable !== 1'b1) begin n_fail++; $display("FAIL idle_odt got %0b exp 1", odt_enable); end
        n_tests++; if (pad_oe !== 1'b0 || cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_oe_cmd got %0b%0b exp 01", pad_oe, cmd_rdy); end
        model_q.delete();
        model_ufl = 1'b0;
    endtask

    task automatic test_burst4();
        logic [LANES-1:0] exp_d [6];
        exp_d = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        odt_req = 1'b1;
        push_beat(8'h11); push_beat(8'h22); push_beat(8'h33); push_beat(8'h44);
        start_burst(1'b0);
        for (int c = 0; c < 6; c++) begin
            n_tests++; if (pad_oe !== 1'b1) begin n_fail++; $display("FAIL b4_oe c=%0d got %0b exp 1", c, pad_oe); end
            n_tests++; if (pad_data !== exp_d[c]) begin n_fail++; $display("FAIL b4_data c=%0d got %0h exp %0h", c, pad_data, exp_d[c]); end
            n_tests++; if (odt_enable !== 1'b0) begin n_fail++; $display("FAIL b4_odt c=%0d got %0b exp 0", c, odt_enable); end
            tick();
        end
        repeat (4) void'(model_q.pop_front());
        n_tests++; if (pad_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b4_end got oe=%0b busy=%0b exp 0 0", pad_oe, busy); end
        n_tests++; if (odt_enable !== 1'b1) begin n_fail++; $display("FAIL b4_end_odt got %0b exp 1", odt_enable); end
        odt_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [LANES-1:0] exp_d;
        logic [LANES-1:0] nb;
        logic             exp_oe;
        int               extra;
        int               oe_cycles;
        extra = 0;
        oe_cycles = 0;
        for (int i = 0; i < DEPTH; i++) push_beat(LANES'($urandom));
        start_burst(1'b1);
        nb = LANES'($urandom);
        for (int c = 1; c <= 15; c++) begin
            exp_oe = (c <= 14);
            exp_d  = 8'h00;
            if (c >= 2 && c <= 13 && model_q.size() > 0) exp_d = model_q.pop_front();
            if (pad_oe) oe_cycles++;
            n_tests++; if (pad_oe !== exp_oe) begin n_fail++; $display("FAIL b2b_oe c=%0d got %0b exp %0b", c, pad_oe, exp_oe); end
            n_tests++; if (pad_data !== exp_d) begin n_fail++; $display("FAIL b2b_data c=%0d got %0h exp %0h", c, pad_data, exp_d); end
            if (c == 5) begin
                n_tests++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_cmd_mid got %0b exp 0", cmd_rdy); end
            end
            if (c == 9 || c == 13) begin
                n_tests++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_cmd_last c=%0d got %0b exp 1", c, cmd_rdy); end
            end
            burst_go   = (c == 9);
            burst_len8 = 1'b0;
            if (extra < 4) begin
                wr_vld  = 1'b1;
                wr_data = nb;
                if (wr_rdy) begin
                    model_q.push_back(nb);
                    extra++;
                    nb = LANES'($urandom);
                end
            end else begin
                wr_vld = 1'b0;
            end
            tick();
        end
        wr_vld = 1'b0;
        burst_go = 1'b0;
        n_tests++; if (oe_cycles != 14) begin n_fail++; $display("FAIL b2b_oe_len got %0d exp 14", oe_cycles); end
    endtask

    task automatic test_underflow();
        logic [LANES-1:0] exp_d;
        logic             exp_u;
        clr_err = 1'b1; tick(); clr_err = 1'b0; model_ufl = 1'b0;
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL ufl_pre got %0b exp 0", underflow); end
        push_beat(LANES'($urandom)); push_beat(LANES'($urandom));
        start_burst(1'b0);
        for (int c = 1; c <= 7; c++) begin
            exp_d = 8'h00;
            if (c >= 2 && c <= 5) begin
                if (model_q.size() > 0) exp_d = model_q.pop_front();
                else model_ufl = 1'b1;
            end
            n_tests++; if (pad_data !== exp_d) begin n_fail++; $display("FAIL ufl_data c=%0d got %0h exp %0h", c, pad_data, exp_d); end
            n_tests++; if (underflow !== model_ufl) begin n_fail++; $display("FAIL ufl_flag c=%0d got %0b exp %0b", c, underflow, model_ufl); end
            n_tests++; if (pad_oe !== (c <= 6)) begin n_fail++; $display("FAIL ufl_oe c=%0d got %0b", c, pad_oe); end
            if (c == 7) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ufl_idle got busy=%0b exp 0", busy); end
            end else tick();
        end
        repeat (3) tick();
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL ufl_sticky got %0b exp 1", underflow); end
        clr_err = 1'b1; tick(); clr_err = 1'b0; model_ufl = 1'b0;
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL ufl_clear got %0b exp 0", underflow); end
        // clr_err held through an underflowing burst: the set must win
        push_beat(LANES'($urandom)); push_beat(LANES'($urandom));
        clr_err = 1'b1;
        start_burst(1'b0);
        for (int c = 1; c <= 7; c++) begin
            exp_u = (c == 4 || c == 5);
            n_tests++; if (underflow !== exp_u) begin n_fail++; $display("FAIL ufl_setwins c=%0d got %0b exp %0b", c, underflow, exp_u); end
            if (c < 7) tick();
        end
        clr_err = 1'b0;
        model_q.delete();
        model_ufl = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [LANES-1:0] exp_d;
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL full_rdy_fill i=%0d got %0b exp 1", i, wr_rdy); end
            push_beat(LANES'($urandom));
        end
        n_tests++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy got %0b exp 0", wr_rdy); end
        push_beat(8'hEE);
        n_tests++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy_9th got %0b exp 0", wr_rdy); end
        start_burst(1'b1);
        for (int c = 1; c <= 11; c++) begin
            if (c == 1) begin
                n_tests++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL full_rdy_pre got %0b exp 0", wr_rdy); end
            end
            if (c == 2) begin
                n_tests++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL full_rdy_pop got %0b exp 1", wr_rdy); end
            end
            exp_d = 8'h00;
            if (c >= 2 && c <= 9 && model_q.size() > 0) exp_d = model_q.pop_front();
            n_tests++; if (pad_data !== exp_d) begin n_fail++; $display("FAIL full_data c=%0d got %0h exp %0h", c, pad_data, exp_d); end
            n_tests++; if (pad_oe !== (c <= 10)) begin n_fail++; $display("FAIL full_oe c=%0d got %0b", c, pad_oe); end
            if (c < 11) tick();
        end
        n_tests++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL full_ufl got %0b exp 0", underflow); end
    endtask

    task automatic test_reset_mid_burst();
        logic [LANES-1:0] exp_d;
        for (int i = 0; i < 4; i++) push_beat(LANES'($urandom));
        start_burst(1'b0);
        repeat (3) tick();
        n_tests++; if (pad_oe !== 1'b1) begin n_fail++; $display("FAIL mid_oe_before got %0b exp 1", pad_oe); end
        #1 rst_l = 1'b0;
        #1;
        n_tests++; if (pad_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async got oe=%0b busy=%0b exp 0 0", pad_oe, busy); end
        n_tests++; if (pad_data !== 8'h00) begin n_fail++; $display("FAIL mid_data got %0h exp 0", pad_data); end
        repeat (2) tick();
        rst_l = 1'b1;
        model_q.delete();
        model_ufl = 1'b0;
        tick();
        n_tests++; if (wr_rdy !== 1'b1 || cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rdy got %0b%0b exp 11", wr_rdy, cmd_rdy); end
        for (int i = 0; i < 4; i++) push_beat(LANES'($urandom));
        start_burst(1'b0);
        for (int c = 1; c <= 6; c++) begin
            exp_d = 8'h00;
            if (c >= 2 && c <= 5 && model_q.size() > 0) exp_d = model_q.pop_front();
            n_tests++; if (pad_data !== exp_d) begin n_fail++; $display("FAIL mid_fresh c=%0d got %0h exp %0h", c, pad_data, exp_d); end
            if (c < 6) tick();
        end
        tick();
        n_tests++; if (underflow !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_end got ufl=%0b busy=%0b exp 0 0", underflow, busy); end
    endtask

    task automatic test_random();
        logic [LANES-1:0] exp_d;
        logic             exp_odt;
        logic             l8;
        int               k;
        int               n;
        for (int it = 0; it < 25; it++) begin
            odt_req = 1'($urandom_range(0, 1));
            clr_err = 1'b1; tick(); clr_err = 1'b0; model_ufl = 1'b0;
            k = $urandom_range(0, DEPTH - model_q.size());
            for (int i = 0; i < k; i++) push_beat(LANES'($urandom));
            l8 = 1'($urandom_range(0, 1));
            n  = l8 ? 8 : 4;
            start_burst(l8);
            for (int c = 1; c <= n + 3; c++) begin
                exp_d = 8'h00;
                if (c >= 2 && c <= n + 1) begin
                    if (model_q.size() > 0) exp_d = model_q.pop_front();
                    else model_ufl = 1'b1;
                end
                exp_odt = (c == n + 3) ? odt_req : 1'b0;
                n_tests++; if (pad_data !== exp_d) begin n_fail++; $display("FAIL rnd_data it=%0d c=%0d got %0h exp %0h", it, c, pad_data, exp_d); end
                n_tests++; if (pad_oe !== (c <= n + 2)) begin n_fail++; $display("FAIL rnd_oe it=%0d c=%0d got %0b", it, c, pad_oe); end
                n_tests++; if (underflow !== model_ufl) begin n_fail++; $display("FAIL rnd_ufl it=%0d c=%0d got %0b exp %0b", it, c, underflow, model_ufl); end
                n_tests++; if (odt_enable !== exp_odt) begin n_fail++; $display("FAIL rnd_odt it=%0d c=%0d got %0b exp %0b", it, c, odt_enable, exp_odt); end
                if (c < n + 3) tick();
            end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle it=%0d got busy=%0b exp 0", it, busy); end
        end
    endtask

    initial begin
        rst_l      = 1'b0;
        wr_vld     = 1'b0;
        wr_data    = '0;
        burst_go   = 1'b0;
        burst_len8 = 1'b0;
        odt_req    = 1'b0;
        clr_err    = 1'b0;
        model_ufl  = 1'b0;
        test_reset();
        test_burst4();
        test_back_to_back();
        test_underflow();
        test_fifo_full();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
